dm_load_responder: RTL

Memory-side responder for the data-memory port. It consumes the byte-lane store requests (address, lane-aligned write data, 4-bit byte enable) produced by the store-side byte-enable logic, and serves loads with byte/halfword extraction and sign/zero extension. Accesses complete after a fixed, programmable number of wait cycles; `busy` stalls the M stage. It sits between the M stage and a word-organised data RAM held inside the block.

---
 rtl/dm_load_responder.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/dm_load_responder.sv
// Data-memory responder: byte-lane stores and sign/zero-extended loads after a
// fixed wait. Optional alignment checking is enabled by defining DM_ALIGN_CHK_EN.

module dm_lane_ram #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] idx,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);
  logic [7:0] mem [2**ADDR_W];

  always_ff @(posedge clk)
    if (we) mem[idx] <= wdata;

  assign rdata = mem[idx];
endmodule

module dm_load_responder #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  input  logic [2:0]  load_op,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic [4:0]  exc_code
);
  localparam int NUM_LANES = 4;

  typedef enum logic {IDLE, WAIT} state_t;

  typedef struct packed {
    logic [ADDR_W+1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        be;
    logic [2:0]        op;
  } req_t;

  state_t                        state;
  req_t                          rq;
  logic [2:0]                    cnt;
  logic                          misal_q;
  logic [4:0]                    exc_q;
  logic                          done;
  logic                          acc_misal;
  logic [NUM_LANES-1:0]          lane_we;
  logic [NUM_LANES-1:0][7:0]     rd_lanes;
  logic                          unused_addr_hi;

  assign unused_addr_hi = ^m_data_addr[31:ADDR_W+2];

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] a,
                                          input logic [2:0] op);
    logic [15:0] h;
    logic [7:0]  b;
    h = a[1] ? w[31:16] : w[15:0];
    b = w[8*a +: 8];
    case (op)
      3'd1:    extract = {{16{h[15]}}, h};
      3'd2:    extract = {16'h0, h};
      3'd3:    extract = {{24{b[7]}}, b};
      3'd4:    extract = {24'h0, b};
      default: extract = w;
    endcase
  endfunction

`ifdef DM_ALIGN_CHK_EN
  function automatic logic misaligned(input logic [1:0] a, input logic [3:0] be,
                                      input logic [2:0] op);
    if (be == 4'b0000)
      misaligned = (op == 3'd0) ? (a != 2'b00) :
                   (op == 3'd1 || op == 3'd2) ? a[0] : 1'b0;
    else if (be == 4'b1111)
      misaligned = (a != 2'b00);
    else if (be == 4'b0011 || be == 4'b1100)
      misaligned = a[0];
    else
      misaligned = 1'b0;
  endfunction

  assign acc_misal = misaligned(m_data_addr[1:0], m_data_byteen, load_op);
  assign exc_code  = exc_q;
`else
  logic unused_exc;
  assign acc_misal  = 1'b0;
  assign exc_code   = 5'd0;
  assign unused_exc = ^exc_q;
`endif

  assign busy    = (state == WAIT);
  assign done    = (state == WAIT) && (cnt == 3'd0);
  assign lane_we = (done && !misal_q) ? rq.be : '0;

  // One byte-wide RAM per lane so partial stores need no read-modify-write.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    dm_lane_ram #(.ADDR_W(ADDR_W)) u_lane (
      .clk   (clk),
      .we    (lane_we[i]),
      .idx   (rq.addr[ADDR_W+1:2]),
      .wdata (rq.wdata[8*i +: 8]),
      .rdata (rd_lanes[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rq         <= '0;
      cnt        <= 3'd0;
      misal_q    <= 1'b0;
      exc_q      <= 5'd0;
      resp_valid <= 1'b0;
      rdata      <= 32'h0;
    end else begin
      resp_valid <= 1'b0;
      exc_q      <= 5'd0;
      case (state)
        IDLE: if (req) begin
          rq      <= '{addr: m_data_addr[ADDR_W+1:0], wdata: m_data_wdata,
                       be: m_data_byteen, op: load_op};
          misal_q <= acc_misal;
          cnt     <= acc_misal ? 3'd0 : 3'(LATENCY - 1);
          state   <= WAIT;
        end
        WAIT: begin
          if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else begin
            state <= IDLE;
            if (rq.be == 4'b0000) begin
              resp_valid <= 1'b1;
              if (misal_q) exc_q <= 5'd4;
              else         rdata <= extract(rd_lanes, rq.addr[1:0], rq.op);
            end else if (misal_q) begin
              exc_q <= 5'd5;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
